uart_tx_sched: RTL and testbench

Round-robin scheduler that shares a single `uart_tx` byte transmitter between `NUM_REQ` requesters. It sits between the requester blocks and the transmitter, and owns the transmitter's `tx_data`, `tx_req` and `tx_done` pins. It supports multi-byte packet locking, so a requester's packet goes out uninterrupted. A watchdog recovers if the transmitter never reports completion.

---
 rtl/uart_tx_sched.sv | 150 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one byte-wide UART transmitter between NUM_REQ requesters.
// Multi-byte packets hold the grant until their last byte; a watchdog recovers from a silent transmitter.
module uart_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [7:0]                 uart_tx_data,
    output logic                       uart_tx_req,
    input  logic                       uart_tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int              GW       = $clog2(NUM_REQ);
    localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]   LAST_RST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               lock_q, lock_d;
    logic               pkt_end_q, pkt_end_d;
    logic [GW-1:0]      last_q, last_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               txreq_q, txreq_d;
    logic               tout_q, tout_d;
    logic               busy_q, busy_d;

    logic [GW-1:0]      rr_sel, rr_idx, sel;
    logic               rr_hit, hit;

    // Scan downward from the farthest candidate so the nearest valid index after last_q wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = '0;
        rr_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = GW'((int'(last_q) + k) % NUM_REQ);
            if (req_valid[rr_idx]) begin
                rr_hit = 1'b1;
                rr_sel = rr_idx;
            end
        end
    end

    // While a packet is open only its owner may be granted, and it may be absent indefinitely.
    assign hit = lock_q ? req_valid[grant_q] : rr_hit;
    assign sel = lock_q ? grant_q : rr_sel;

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        pkt_end_d = pkt_end_q;
        last_d    = last_q;
        grant_d   = grant_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        ready_d   = '0;
        done_d    = '0;
        txreq_d   = 1'b0;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    grant_d      = sel;
                    data_d       = req_data[{sel, 3'b000} +: 8];
                    pkt_end_d    = req_last[sel];
                    ready_d[sel] = 1'b1;
                    txreq_d      = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 16'd1;
                if (uart_tx_done) begin
                    done_d[grant_q] = 1'b1;
                    lock_d          = ~pkt_end_q;
                    last_d          = grant_q;
                    state_d         = IDLE;
                end else if (cnt_q == WD_LAST) begin
                    tout_d  = 1'b1;
                    lock_d  = 1'b0;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            lock_q    <= 1'b0;
            pkt_end_q <= 1'b0;
            last_q    <= LAST_RST;
            grant_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            ready_q   <= '0;
            done_q    <= '0;
            txreq_q   <= 1'b0;
            tout_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            pkt_end_q <= pkt_end_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            txreq_q   <= txreq_d;
            tout_q    <= tout_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ready    = ready_q;
    assign req_done     = done_q;
    assign uart_tx_data = data_q;
    assign uart_tx_req  = txreq_q;
    assign grant_id     = grant_q;
    assign busy         = busy_q;
    assign timeout_err  = tout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: random requesters/packets and a transmitter stub,
// checked against a transaction-level timeline model.
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int T   = 50;
    localparam int CYC = 4000;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic [N-1:0]   req_valid, req_last, req_ready, req_done;
    logic [N*8-1:0] req_data;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_req, uart_tx_done;
    logic [1:0]     grant_id;
    logic           busy, timeout_err;

    int n_chk = 0;
    int n_err = 0;
    int x;

    // Timeline model of the most recent grant.
    int         g_cyc, free_cyc, dc, gi, last;
    logic [7:0] gdata;
    bit         lock, end_done, have;

    // Requesters.
    bit         rv[N];
    logic [7:0] rd[N];
    bit         rl[N];
    int         rem[N];

    uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .req_done(req_done),
        .uart_tx_data(uart_tx_data), .uart_tx_req(uart_tx_req), .uart_tx_done(uart_tx_done),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s x=%0d got=%h exp=%h", tag, x, got, exp);
        end
    endtask

    function automatic logic [31:0] oh(int i);
        return 32'(1) << i;
    endfunction

    task automatic model_reset();
        g_cyc = -100; free_cyc = 0; dc = -1; gi = 0; last = N - 1;
        gdata = 8'h00; lock = 0; end_done = 0; have = 0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_txreq"},   32'(uart_tx_req),  0);
        check({tag, "_ready"},   32'(req_ready),    0);
        check({tag, "_done"},    32'(req_done),     0);
        check({tag, "_busy"},    32'(busy),         0);
        check({tag, "_timeout"}, 32'(timeout_err),  0);
        check({tag, "_grant"},   32'(grant_id),     0);
        check({tag, "_data"},    32'(uart_tx_data), 0);
    endtask

    task automatic check_outputs();
        bit sendc, endc;
        sendc = have && (x == g_cyc + 1);
        endc  = have && (x == free_cyc);
        check("tx_req",  32'(uart_tx_req), 32'(sendc));
        check("ready",   32'(req_ready),   sendc ? oh(gi) : 0);
        check("grant",   32'(grant_id),    32'(gi));
        check("data",    32'(uart_tx_data), 32'(gdata));
        check("busy",    32'(busy),        32'(have && x >= g_cyc + 1 && x < free_cyc));
        check("done",    32'(req_done),    (endc && end_done) ? oh(gi) : 0);
        check("timeout", 32'(timeout_err), 32'(endc && !end_done));
    endtask

    task automatic consume();
        if (have && x == g_cyc + 1) begin
            rv[gi] = 0;
            rem[gi]--;
        end
    endtask

    task automatic arm_and_drive();
        bit in_wait;
        for (int i = 0; i < N; i++) begin
            if (!rv[i] && ($urandom % 3 == 0)) begin
                if (rem[i] <= 0) rem[i] = 1 + int'($urandom % 3);
                rd[i] = 8'($urandom);
                rl[i] = (rem[i] == 1);
                rv[i] = 1;
            end
            req_valid[i]      = rv[i];
            req_data[i*8 +: 8] = rd[i];
            req_last[i]       = rl[i];
        end
        in_wait = have && (x >= g_cyc + 2) && (x < free_cyc);
        if (x == dc)
            uart_tx_done = 1'b1;
        else
            uart_tx_done = (!in_wait && ($urandom % 16 == 0));
    endtask

    // Grant decision for the current cycle; outcome of the transfer is fixed by the stub delay.
    task automatic model_step();
        int e, d, r;
        if (x < free_cyc) return;
        e = -1;
        if (lock) begin
            if (rv[gi]) e = gi;
        end else begin
            for (int k = 1; k <= N; k++)
                if (e < 0 && rv[(last + k) % N]) e = (last + k) % N;
        end
        if (e < 0) return;
        r = int'($urandom % 8);
        if (r < 2)       d = T;
        else if (r == 2) d = T - 1;
        else if (r == 3) d = 0;
        else             d = 1 + int'($urandom % 12);
        gi = e; gdata = rd[e]; g_cyc = x; have = 1; last = e;
        if (d >= 1 && d <= T) begin
            dc = x + 1 + d; free_cyc = dc + 1; end_done = 1; lock = !rl[e];
        end else begin
            dc = -1; free_cyc = x + 2 + T; end_done = 0; lock = 0;
        end
    endtask

    initial begin
        bit rst_pending;
        sys_rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; uart_tx_done = 1'b0;
        for (int i = 0; i < N; i++) begin rv[i] = 0; rd[i] = 8'h00; rl[i] = 0; rem[i] = 0; end
        model_reset();
        x = 0;
        rst_pending = 0;
        @(negedge sys_clk);
        check_reset_outputs("por");
        sys_rst = 1'b0;
        for (int i = 0; i < CYC; i++) begin
            check_outputs();
            consume();
            if (i % 700 == 350) rst_pending = 1;
            if (rst_pending && have && x >= g_cyc + 2 && x < free_cyc) begin
                rst_pending = 0;
                sys_rst = 1'b1;
                #1;
                check_reset_outputs("arst");
                @(negedge sys_clk);
                check_reset_outputs("rsthold");
                sys_rst = 1'b0;
                model_reset();
                x = 0;
            end
            arm_and_drive();
            model_step();
            @(negedge sys_clk);
            x++;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
